regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with a write-back scoreboard, the successor to the processor's single-cycle 16x16 register file. It provides two combinational read ports, one write-back port and a flags register. It also tracks which registers have an in-flight result and raises `stall` on RAW/WAW hazards, so the decode stage can issue into a multi-cycle execute pipeline.

## Interface
- `DATA_W`, 16: register and bus width.
- `ADDR_W`, 4: register address width; depth = 2**ADDR_W.
- `FLAG_W`, 2: flags width (bit1 carry/borrow, bit0 zero by convention).
- `ZERO_REG`, 0: 1 = register 0 reads 0, ignores writes, never pending.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rd1_addr`, `rd2_addr` in ADDR_W: read port selects (Rx, Ry).
- `rd1_data`, `rd2_data` out DATA_W: combinational read data.
- `iss_valid` in 1: decode presents an instruction this cycle.
- `iss_use1`, `iss_use2` in 1: instruction sources rd1_addr / rd2_addr.
- `iss_wr` in 1: instruction will write `iss_dst`.
- `iss_dst` in ADDR_W: destination register.
- `stall` out 1: combinational; issue not accepted this cycle.
- `wb_en` in 1: write-back strobe.
- `wb_addr` in ADDR_W, `wb_data` in DATA_W: write-back target/value.
- `flags_we` in 1, `flags_in` in FLAG_W: flags update.
- `flags` out FLAG_W: registered flags.
- `pending` out 2**ADDR_W: scoreboard bit per register.
- `wb_err` out 1: sticky; write-back to a non-pending register.

## Operation
- Reads: `rdN_data = regs[rdN_addr]`, subject to bypass (Configuration) and ZERO_REG.
- Write: on `wb_en`, `regs[wb_addr] <= wb_data` at the rising edge.
- Hazard terms are evaluated only when `iss_valid`=1:
  - `p(a)` = `pending[a]`, excluding a same-cycle clear (see Configuration).
  - RAW = (`iss_use1` & p(rd1_addr)) | (`iss_use2` & p(rd2_addr)).
  - WAW = `iss_wr` & p(iss_dst).
  - `stall` = `iss_valid` & (RAW | WAW); `stall`=0 when `iss_valid`=0.
- Accept = `iss_valid` & !`stall`. On accept with `iss_wr`, `pending[iss_dst]` is set at the edge.
- `wb_en` clears `pending[wb_addr]` at the edge.
- Same edge, same register, set and clear: set wins; the register stays pending for the new instruction.
- `wb_en` to a register whose pending bit is 0 (pre-edge) still writes, and sets `wb_err`=1 until reset.
- ZERO_REG=1:
  - Writes to register 0 are dropped.
  - Register 0 reads 0.
  - `pending[0]` is never set.
  - wb to register 0 never flags `wb_err`.
- `flags_we`: `flags <= flags_in`; otherwise flags hold. Flags are not scoreboarded.

## Timing
- Reset (async assert): all registers 0, `pending`=0, `flags`=0, `wb_err`=0. These take effect immediately, independent of `clk`.
- Reset mid-operation discards all in-flight pending state; the first edge after deassert behaves as a fresh start.
- Read latency 0: combinational from address.
- Write visible on the stored path the cycle after `wb_en`.
- `pending` and `wb_err` update one edge after the causing event.
- `stall` has combinational paths from `iss_*`, `rd*_addr`, `pending`, and (with bypass) `wb_*`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `wb_en` and `wb_addr == rdN_addr`, `rdN_data = wb_data` in the same cycle.
  - `p(a)` excludes a register being cleared by this cycle's write-back, so dependent instructions issue with zero bubble.
- Undefined:
  - Read data is the stored value only.
  - `p(a)` is the raw `pending[a]`, so a dependent instruction stalls through the write-back cycle and issues the next cycle (one bubble).

## Test plan
- Reset with `reset`=1 mid-clock while r3=0x1234 and `pending[3]`=1 -> immediately `rd1_data`=0 for addr 3, `pending`=0, `flags`=0, `wb_err`=0.
- Write r5=0xBEEF, next cycle read `rd1_addr`=5, `rd2_addr`=5 -> both 0xBEEF. Same-cycle read during the write -> 0xBEEF with bypass, 0x0000 without.
- Issue `iss_wr`, dst=2 (accepted) -> `pending[2]`=1. Next cycle `iss_use1`, rd1_addr=2 -> `stall`=1. When wb to 2 occurs -> `stall`=0 that cycle with bypass, 0 only the following cycle without.
- Issue dst=4 accepted in the same cycle as `wb_en`, `wb_addr`=4 -> `pending[4]`=1 afterwards, and no WAW stall only if r4 was being cleared under bypass.
- `wb_en`, `wb_addr`=7 with `pending[7]`=0 -> r7 updated, `wb_err`=1, holding until reset.
- ZERO_REG=1: wb r0=0xFFFF, then read r0 -> 0. `flags_we`=1, `flags_in`=2'b10 -> `flags`=2'b10 next cycle and held while `flags_we`=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, issue/hazard handshake, write-back, flags.
// master = decode/execute side, slave = register file.
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 2
);
    logic [ADDR_W-1:0]        rd1_addr;
    logic [ADDR_W-1:0]        rd2_addr;
    logic [DATA_W-1:0]        rd1_data;
    logic [DATA_W-1:0]        rd2_data;
    logic                     iss_valid;
    logic                     iss_use1;
    logic                     iss_use2;
    logic                     iss_wr;
    logic [ADDR_W-1:0]        iss_dst;
    logic                     stall;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flags_we;
    logic [FLAG_W-1:0]        flags_in;
    logic [FLAG_W-1:0]        flags;
    logic [(1<<ADDR_W)-1:0]   pending;
    logic                     wb_err;

    modport master (
        output rd1_addr, rd2_addr, iss_valid, iss_use1, iss_use2, iss_wr, iss_dst,
               wb_en, wb_addr, wb_data, flags_we, flags_in,
        input  rd1_data, rd2_data, stall, flags, pending, wb_err
    );

    modport slave (
        input  rd1_addr, rd2_addr, iss_valid, iss_use1, iss_use2, iss_wr, iss_dst,
               wb_en, wb_addr, wb_data, flags_we, flags_in,
        output rd1_data, rd2_data, stall, flags, pending, wb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-back scoreboard, RAW/WAW stall, flags and sticky wb_err.
// Optional REGFILE_BYPASS_EN: write-back data forwarded to reads and clears hazards same cycle.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int FLAG_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              wb_err_q;
    logic              wb_err_d;

    logic [DEPTH-1:0]  pend_eff_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic              raw_s;
    logic              waw_s;
    logic              stall_s;
    logic              accept_s;
    logic              wb_keep_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 1'b1) && (a == {ADDR_W{1'b0}});
    endfunction

    // Read muxes, including write-back forwarding and the hardwired zero register
    always_comb begin
        rd1_s = regs_q[bus.rd1_addr];
        rd2_s = regs_q[bus.rd2_addr];
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_en && (bus.wb_addr == bus.rd1_addr)) begin
            rd1_s = bus.wb_data;
        end else begin
            rd1_s = regs_q[bus.rd1_addr];
        end
        if (bus.wb_en && (bus.wb_addr == bus.rd2_addr)) begin
            rd2_s = bus.wb_data;
        end else begin
            rd2_s = regs_q[bus.rd2_addr];
        end
`endif
        if (is_zero_reg(bus.rd1_addr)) begin
            rd1_s = {DATA_W{1'b0}};
        end else begin
            rd1_s = rd1_s;
        end
        if (is_zero_reg(bus.rd2_addr)) begin
            rd2_s = {DATA_W{1'b0}};
        end else begin
            rd2_s = rd2_s;
        end
    end

    // Hazard detection; with forwarding a register retiring this cycle no longer blocks
    always_comb begin
        pend_eff_s = pending_q;
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_en) begin
            pend_eff_s[bus.wb_addr] = 1'b0;
        end else begin
            pend_eff_s = pending_q;
        end
`endif
        raw_s   = 1'b0;
        waw_s   = 1'b0;
        stall_s = 1'b0;
        if (bus.iss_valid) begin
            raw_s   = (bus.iss_use1 & pend_eff_s[bus.rd1_addr]) |
                      (bus.iss_use2 & pend_eff_s[bus.rd2_addr]);
            waw_s   = bus.iss_wr & pend_eff_s[bus.iss_dst];
            stall_s = raw_s | waw_s;
        end else begin
            stall_s = 1'b0;
        end
        accept_s  = bus.iss_valid & ~stall_s;
        wb_keep_s = bus.wb_en & ~is_zero_reg(bus.wb_addr);
    end

    // Scoreboard, error and flags next state; a new issue wins over a same-edge clear
    always_comb begin
        pending_d = pending_q;
        wb_err_d  = wb_err_q;
        flags_d   = flags_q;
        if (bus.wb_en) begin
            pending_d[bus.wb_addr] = 1'b0;
            if (!pending_q[bus.wb_addr] && !is_zero_reg(bus.wb_addr)) begin
                wb_err_d = 1'b1;
            end else begin
                wb_err_d = wb_err_q;
            end
        end else begin
            wb_err_d = wb_err_q;
        end
        if (accept_s && bus.iss_wr && !is_zero_reg(bus.iss_dst)) begin
            pending_d[bus.iss_dst] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        if (bus.flags_we) begin
            flags_d = bus.flags_in;
        end else begin
            flags_d = flags_q;
        end
    end

    // Register array storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_keep_s) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard, flags and sticky error state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= {DEPTH{1'b0}};
            flags_q   <= {FLAG_W{1'b0}};
            wb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            flags_q   <= flags_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign bus.rd1_data = rd1_s;
    assign bus.rd2_data = rd2_s;
    assign bus.stall    = stall_s;
    assign bus.pending  = pending_q;
    assign bus.flags    = flags_q;
    assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (ZERO_REG=1); expectations follow
// whether REGFILE_BYPASS_EN is defined for the build.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .FLAG_W(2)) bus ();

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .FLAG_W(2), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd1_addr = 4'd0; bus.rd2_addr = 4'd0;
        bus.iss_valid = 1'b0; bus.iss_use1 = 1'b0; bus.iss_use2 = 1'b0;
        bus.iss_wr = 1'b0; bus.iss_dst = 4'd0;
        bus.wb_en = 1'b0; bus.wb_addr = 4'd0; bus.wb_data = 16'h0000;
        bus.flags_we = 1'b0; bus.flags_in = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        step();
    endtask

    task automatic issue_wr(input logic [3:0] dst);
        idle();
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_dst = dst;
        step();
        idle();
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.pending !== 16'h0000) begin bad++; $display("FAIL rst_pending: got %h want 0000", bus.pending); end
        total++; if (bus.flags !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", bus.flags); end
        total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL rst_wb_err: got %b want 0", bus.wb_err); end
        bus.rd1_addr = 4'd9; #1;
        total++; if (bus.rd1_data !== 16'h0000) begin bad++; $display("FAIL rst_rd: got %h want 0000", bus.rd1_data); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        issue_wr(4'd5);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 16'hBEEF; bus.rd1_addr = 4'd5;
        #1;
        total++; if (bus.rd1_data !== (BYP ? 16'hBEEF : 16'h0000)) begin bad++; $display("FAIL wr_same_cycle: got %h want %h", bus.rd1_data, BYP ? 16'hBEEF : 16'h0000); end
        step();
        idle(); bus.rd1_addr = 4'd5; bus.rd2_addr = 4'd5; #1;
        total++; if (bus.rd1_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd1: got %h want BEEF", bus.rd1_data); end
        total++; if (bus.rd2_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd2: got %h want BEEF", bus.rd2_data); end
        total++; if (bus.pending !== 16'h0000) begin bad++; $display("FAIL wr_pending: got %h want 0000", bus.pending); end
        total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL wr_wb_err: got %b want 0", bus.wb_err); end
    endtask

    task automatic test_hazard();
        issue_wr(4'd2);
        total++; if (bus.pending !== 16'h0004) begin bad++; $display("FAIL hz_pending_set: got %h want 0004", bus.pending); end
        bus.iss_valid = 1'b1; bus.iss_use1 = 1'b1; bus.rd1_addr = 4'd2; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hz_raw1: got %b want 1", bus.stall); end
        step();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 16'h0022; #1;
        total++; if (bus.stall !== ~BYP) begin bad++; $display("FAIL hz_wb_cycle: got %b want %b", bus.stall, ~BYP); end
        total++; if (bus.rd1_data !== (BYP ? 16'h0022 : 16'h0000)) begin bad++; $display("FAIL hz_fwd: got %h want %h", bus.rd1_data, BYP ? 16'h0022 : 16'h0000); end
        step();
        bus.wb_en = 1'b0; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL hz_after_wb: got %b want 0", bus.stall); end
        total++; if (bus.rd1_data !== 16'h0022) begin bad++; $display("FAIL hz_rd_after: got %h want 0022", bus.rd1_data); end
        issue_wr(4'd6);
        bus.iss_valid = 1'b1; bus.iss_use2 = 1'b1; bus.rd2_addr = 4'd6; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hz_raw2: got %b want 1", bus.stall); end
        bus.iss_use2 = 1'b0; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL hz_no_use: got %b want 0", bus.stall); end
        bus.iss_wr = 1'b1; bus.iss_dst = 4'd6; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hz_waw: got %b want 1", bus.stall); end
        bus.iss_valid = 1'b0; bus.iss_use1 = 1'b1; bus.rd1_addr = 4'd6; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL hz_not_valid: got %b want 0", bus.stall); end
        idle(); bus.wb_en = 1'b1; bus.wb_addr = 4'd6; bus.wb_data = 16'h0066;
        step();
        idle(); #1;
        total++; if (bus.pending !== 16'h0000) begin bad++; $display("FAIL hz_cleared: got %h want 0000", bus.pending); end
    endtask

    task automatic test_set_clear();
        issue_wr(4'd4);
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_dst = 4'd4;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 16'h0044; #1;
        total++; if (bus.stall !== ~BYP) begin bad++; $display("FAIL sc_waw: got %b want %b", bus.stall, ~BYP); end
        step();
        idle(); #1;
        total++; if (bus.pending !== (BYP ? 16'h0010 : 16'h0000)) begin bad++; $display("FAIL sc_pending4: got %h want %h", bus.pending, BYP ? 16'h0010 : 16'h0000); end
        total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL sc_no_err: got %b want 0", bus.wb_err); end
        do_reset();
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_dst = 4'd8;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd8; bus.wb_data = 16'h0088; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL sc8_stall: got %b want 0", bus.stall); end
        step();
        idle(); bus.rd1_addr = 4'd8; #1;
        total++; if (bus.pending !== 16'h0100) begin bad++; $display("FAIL sc8_set_wins: got %h want 0100", bus.pending); end
        total++; if (bus.rd1_data !== 16'h0088) begin bad++; $display("FAIL sc8_data: got %h want 0088", bus.rd1_data); end
    endtask

    task automatic test_wb_err();
        do_reset();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 16'h7777;
        step();
        idle(); bus.rd2_addr = 4'd7; #1;
        total++; if (bus.rd2_data !== 16'h7777) begin bad++; $display("FAIL err_data: got %h want 7777", bus.rd2_data); end
        total++; if (bus.wb_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.wb_err); end
        issue_wr(4'd7);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 16'h0007;
        step(); idle(); step(); step();
        total++; if (bus.wb_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.wb_err); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 16'hFFFF; bus.rd1_addr = 4'd0; #1;
        total++; if (bus.rd1_data !== 16'h0000) begin bad++; $display("FAIL z_same_cycle: got %h want 0000", bus.rd1_data); end
        step();
        idle(); bus.rd1_addr = 4'd0; bus.rd2_addr = 4'd0; #1;
        total++; if (bus.rd1_data !== 16'h0000) begin bad++; $display("FAIL z_rd1: got %h want 0000", bus.rd1_data); end
        total++; if (bus.rd2_data !== 16'h0000) begin bad++; $display("FAIL z_rd2: got %h want 0000", bus.rd2_data); end
        total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL z_no_err: got %b want 0", bus.wb_err); end
        issue_wr(4'd0);
        total++; if (bus.pending !== 16'h0000) begin bad++; $display("FAIL z_no_pending: got %h want 0000", bus.pending); end
    endtask

    task automatic test_flags();
        bus.flags_we = 1'b1; bus.flags_in = 2'b10;
        step();
        total++; if (bus.flags !== 2'b10) begin bad++; $display("FAIL fl_write: got %b want 10", bus.flags); end
        bus.flags_we = 1'b0; bus.flags_in = 2'b01;
        step(); step();
        total++; if (bus.flags !== 2'b10) begin bad++; $display("FAIL fl_hold: got %b want 10", bus.flags); end
        bus.flags_we = 1'b1;
        step();
        total++; if (bus.flags !== 2'b01) begin bad++; $display("FAIL fl_rewrite: got %b want 01", bus.flags); end
        idle();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234;
        step();
        idle();
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_dst = 4'd3;
        bus.flags_we = 1'b1; bus.flags_in = 2'b01;
        step();
        idle(); bus.rd1_addr = 4'd3; #1;
        total++; if (bus.rd1_data !== 16'h1234) begin bad++; $display("FAIL mr_pre_data: got %h want 1234", bus.rd1_data); end
        total++; if (bus.pending !== 16'h0008) begin bad++; $display("FAIL mr_pre_pending: got %h want 0008", bus.pending); end
        reset = 1'b1; #1;
        total++; if (bus.rd1_data !== 16'h0000) begin bad++; $display("FAIL mr_data: got %h want 0000", bus.rd1_data); end
        total++; if (bus.pending !== 16'h0000) begin bad++; $display("FAIL mr_pending: got %h want 0000", bus.pending); end
        total++; if (bus.flags !== 2'b00) begin bad++; $display("FAIL mr_flags: got %b want 00", bus.flags); end
        total++; if (bus.wb_err !== 1'b0) begin bad++; $display("FAIL mr_wb_err: got %b want 0", bus.wb_err); end
        reset = 1'b0;
        step();
        bus.iss_valid = 1'b1; bus.iss_use1 = 1'b1; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mr_fresh_stall: got %b want 0", bus.stall); end
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_hazard();
        test_set_clear();
        test_zero_reg();
        test_flags();
        test_wb_err();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
